spi_slave_tx_serializer: RTL



---
 rtl/spi_slave_pkg.sv | 12 +
 rtl/spi_slave_tx_serializer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave datapath.
// Holds the transmit FSM state type and the default word width.
package spi_slave_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

endpackage

// File: rtl/spi_slave_tx_serializer.sv
// SPI slave transmit serializer: pops words from the FIFO read side and
// shifts them out MSB-first on shift strobes, with one prefetch word.
// Ports: clk/rstn (sync, active-low); data_i/valid_i/ready_o FIFO side;
// shift_en_i bit strobe; len_i bits-per-word minus 1; abort_i flush;
// sdo_o serial out; word_done_o last-bit pulse; underrun_o empty strobe.
module spi_slave_tx_serializer
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_WORD_W,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  shift_en_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  output logic                  sdo_o,
  output logic                  word_done_o,
  output logic                  underrun_o
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] pf_q, pf_d;
  logic                  pf_valid_q, pf_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;

  logic accept;
  logic last_bit;
  logic word_done;
  logic underrun;

  // Ready depends on registers only, never on valid_i.
  assign ready_o  = rstn && !pf_valid_q;
  assign accept   = valid_i && ready_o;
  assign last_bit = (cnt_q == len_q);

  assign sdo_o       = rstn && (state_q == TX_SHIFT)
                       && sr_q[DATA_WIDTH-1];
  assign word_done_o = rstn && word_done;
  assign underrun_o  = rstn && underrun;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    word_done  = 1'b0;
    underrun   = 1'b0;

    if (abort_i) begin
      // Flush everything; a word accepted now is dropped.
      state_d    = TX_IDLE;
      pf_valid_d = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          underrun = shift_en_i;
          if (pf_valid_q) begin
            sr_d       = pf_q;
            pf_valid_d = 1'b0;
            state_d    = TX_SHIFT;
            cnt_d      = '0;
            len_d      = len_i;
          end else if (accept) begin
            sr_d    = data_i;
            state_d = TX_SHIFT;
            cnt_d   = '0;
            len_d   = len_i;
          end
        end
        TX_SHIFT: begin
          if (shift_en_i && last_bit) begin
            word_done = 1'b1;
            if (pf_valid_q) begin
              sr_d       = pf_q;
              pf_valid_d = 1'b0;
              cnt_d      = '0;
              len_d      = len_i;
            end else if (accept) begin
              sr_d  = data_i;
              cnt_d = '0;
              len_d = len_i;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            if (shift_en_i) begin
              sr_d  = sr_q << 1;
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            if (accept) begin
              pf_d       = data_i;
              pf_valid_d = 1'b1;
            end
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= TX_IDLE;
      sr_q       <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      cnt_q      <= '0;
      len_q      <= CNT_WIDTH'(DATA_WIDTH - 1);
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

endmodule
